hamming_secded_16_11: RTL and testbench

//  Extended Hamming (16,11) SECDED codec: registered encoder + registered decoder, independent paths.

---
 rtl/hamming_pkg.sv | 55 +++++
 rtl/hamming_secded_dec_core.sv | 39 +++
 rtl/hamming_secded_16_11.sv | 115 +++++++++++
 tb/tb_hamming_secded_16_11.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared constants, error classes and codec functions for the extended Hamming (16,11) SECDED codec.
// Codeword bit 0 is overall parity; bits 1,2,4,8 are Hamming parity; the rest carry data.
package hamming_pkg;

    localparam int unsigned DATA_W = 11;
    localparam int unsigned CODE_W = 16;
    localparam int unsigned SYN_W  = 4;

    localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SINGLE,
        ERR_DOUBLE
    } err_class_e;

    function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CODE_W-1:0] cw);
        logic [SYN_W-1:0] syn;
        syn = '0;
        for (int unsigned j = 0; j < CODE_W; j++) begin
            for (int unsigned i = 0; i < SYN_W; i++) begin
                if (((j >> i) & 1) != 0) begin
                    syn[i] = syn[i] ^ cw[j];
                end
            end
        end
        return syn;
    endfunction

    // Syndrome of the data-only word is exactly the set of Hamming parity bits needed.
    function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
        logic [CODE_W-1:0] cw;
        logic [SYN_W-1:0]  syn;
        cw = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            cw[DATA_POS[i]] = data[i];
        end
        syn = hamming_syndrome(cw);
        for (int unsigned i = 0; i < SYN_W; i++) begin
            cw[1 << i] = syn[i];
        end
        cw[0] = ^cw[CODE_W-1:1];
        return cw;
    endfunction

    function automatic logic [DATA_W-1:0] hamming_extract(input logic [CODE_W-1:0] cw);
        logic [DATA_W-1:0] data;
        data = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            data[i] = cw[DATA_POS[i]];
        end
        return data;
    endfunction

endpackage

// File: rtl/hamming_secded_dec_core.sv
// Combinational SECDED decode: syndrome, overall parity, error class and single-bit correction.
// Double errors pass the received word through untouched.
module hamming_secded_dec_core
    import hamming_pkg::*;
(
    input  logic [15:0] i_codeword,
    output logic [15:0] o_corrected,
    output logic [3:0]  o_syndrome,
    output logic        o_sed,
    output logic        o_ded
);

    logic [SYN_W-1:0]  w_syn;
    logic              w_par;
    logic [CODE_W-1:0] w_flip;
    err_class_e        w_class;

    always_comb begin
        w_syn  = hamming_syndrome(i_codeword);
        w_par  = ^i_codeword;
        w_flip = '0;
        w_flip[w_syn] = 1'b1;

        // Odd overall parity means one flip; syndrome 0 then points at bit 0 itself.
        if (w_par) begin
            w_class = ERR_SINGLE;
        end else if (w_syn != '0) begin
            w_class = ERR_DOUBLE;
        end else begin
            w_class = ERR_NONE;
        end

        o_corrected = (w_class == ERR_SINGLE) ? (i_codeword ^ w_flip) : i_codeword;
        o_syndrome  = w_syn;
        o_sed       = (w_class == ERR_SINGLE);
        o_ded       = (w_class == ERR_DOUBLE);
    end

endmodule

// File: rtl/hamming_secded_16_11.sv
// Registered extended Hamming (16,11) SECDED encoder and decoder with independent paths.
// Optional saturating sed/ded event counters are built when HAMMING_ERR_CNT_EN is defined.
module hamming_secded_16_11
    import hamming_pkg::*;
`ifdef HAMMING_ERR_CNT_EN
#(
    parameter int unsigned CNT_W = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enc_valid_in,
    input  logic [10:0] enc_data_in,
    output logic        enc_valid_out,
    output logic [15:0] enc_codeword_out,
    input  logic        dec_valid_in,
    input  logic [15:0] dec_codeword_in,
    output logic        dec_valid_out,
    output logic [15:0] dec_codeword_out,
    output logic [10:0] dec_data_out,
    output logic [3:0]  dec_syndrome,
    output logic        dec_sed,
    output logic        dec_ded
`ifdef HAMMING_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] sed_count,
    output logic [CNT_W-1:0] ded_count
`endif
);

    logic              r_enc_valid;
    logic [CODE_W-1:0] r_enc_cw;
    logic              r_dec_valid;
    logic [CODE_W-1:0] r_dec_cw;
    logic [SYN_W-1:0]  r_dec_syn;
    logic              r_dec_sed;
    logic              r_dec_ded;

    logic [CODE_W-1:0] w_corr;
    logic [SYN_W-1:0]  w_syn;
    logic              w_sed;
    logic              w_ded;

    hamming_secded_dec_core u_dec_core (
        .i_codeword  (dec_codeword_in),
        .o_corrected (w_corr),
        .o_syndrome  (w_syn),
        .o_sed       (w_sed),
        .o_ded       (w_ded)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enc_valid <= 1'b0;
            r_enc_cw    <= '0;
        end else begin
            r_enc_valid <= enc_valid_in;
            if (enc_valid_in) begin
                r_enc_cw <= hamming_encode(enc_data_in);
            end
        end
    end

    // Codeword holds across idle cycles, but status flags describe only the current beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec_valid <= 1'b0;
            r_dec_cw    <= '0;
            r_dec_syn   <= '0;
            r_dec_sed   <= 1'b0;
            r_dec_ded   <= 1'b0;
        end else begin
            r_dec_valid <= dec_valid_in;
            if (dec_valid_in) begin
                r_dec_cw <= w_corr;
            end
            r_dec_syn <= dec_valid_in ? w_syn : '0;
            r_dec_sed <= dec_valid_in & w_sed;
            r_dec_ded <= dec_valid_in & w_ded;
        end
    end

    assign enc_valid_out    = r_enc_valid;
    assign enc_codeword_out = r_enc_cw;
    assign dec_valid_out    = r_dec_valid;
    assign dec_codeword_out = r_dec_cw;
    assign dec_data_out     = hamming_extract(r_dec_cw);
    assign dec_syndrome     = r_dec_syn;
    assign dec_sed          = r_dec_sed;
    assign dec_ded          = r_dec_ded;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] r_sed_cnt;
    logic [CNT_W-1:0] r_ded_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sed_cnt <= '0;
            r_ded_cnt <= '0;
        end else begin
            if (r_dec_valid && r_dec_sed && (r_sed_cnt != '1)) begin
                r_sed_cnt <= r_sed_cnt + CNT_W'(1);
            end
            if (r_dec_valid && r_dec_ded && (r_ded_cnt != '1)) begin
                r_ded_cnt <= r_ded_cnt + CNT_W'(1);
            end
        end
    end

    assign sed_count = r_sed_cnt;
    assign ded_count = r_ded_cnt;
`endif

endmodule

// File: tb/tb_hamming_secded_16_11.sv
// Scoreboard bench for hamming_secded_16_11: the driver queues model predictions, the monitor checks them.
// Counter ports are connected and checked when HAMMING_ERR_CNT_EN is defined.
module tb_hamming_secded_16_11;

    typedef struct {
        bit          v;
        logic [15:0] cw;
    } enc_exp_t;

    typedef struct {
        bit          v;
        logic [15:0] cw;
        logic [10:0] data;
        logic [3:0]  syn;
        bit          sed;
        bit          ded;
    } dec_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enc_valid_in = 1'b0;
    logic [10:0] enc_data_in = '0;
    logic        enc_valid_out;
    logic [15:0] enc_codeword_out;
    logic        dec_valid_in = 1'b0;
    logic [15:0] dec_codeword_in = '0;
    logic        dec_valid_out;
    logic [15:0] dec_codeword_out;
    logic [10:0] dec_data_out;
    logic [3:0]  dec_syndrome;
    logic        dec_sed;
    logic        dec_ded;
`ifdef HAMMING_ERR_CNT_EN
    logic [15:0] sed_count;
    logic [15:0] ded_count;
    logic [15:0] exp_sed_cnt = '0;
    logic [15:0] exp_ded_cnt = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    enc_exp_t enc_q[$];
    dec_exp_t dec_q[$];
    logic [15:0] hold_enc_cw  = '0;
    logic [15:0] hold_dec_cw  = '0;
    logic [10:0] hold_dec_dat = '0;

    hamming_secded_16_11 dut (
        .clk              (clk),
        .rst              (rst),
        .enc_valid_in     (enc_valid_in),
        .enc_data_in      (enc_data_in),
        .enc_valid_out    (enc_valid_out),
        .enc_codeword_out (enc_codeword_out),
        .dec_valid_in     (dec_valid_in),
        .dec_codeword_in  (dec_codeword_in),
        .dec_valid_out    (dec_valid_out),
        .dec_codeword_out (dec_codeword_out),
        .dec_data_out     (dec_data_out),
        .dec_syndrome     (dec_syndrome),
        .dec_sed          (dec_sed),
        .dec_ded          (dec_ded)
`ifdef HAMMING_ERR_CNT_EN
        ,
        .sed_count        (sed_count),
        .ded_count        (ded_count)
`endif
    );

    always #5 clk = ~clk;

    // Data fills the non-power-of-two positions in ascending order.
    function automatic logic [15:0] m_encode(input logic [10:0] d);
        logic [15:0] cw;
        int unsigned idx;
        int unsigned s;
        cw  = '0;
        idx = 0;
        s   = 0;
        for (int unsigned k = 1; k < 16; k++) begin
            if ((k & (k - 1)) != 0) begin
                cw[k] = d[idx];
                idx++;
            end
        end
        for (int unsigned k = 0; k < 16; k++) if (cw[k]) s = s ^ k;
        cw[1] = s[0];
        cw[2] = s[1];
        cw[4] = s[2];
        cw[8] = s[3];
        cw[0] = ($countones(cw) % 2) != 0;
        return cw;
    endfunction

    function automatic logic [10:0] m_extract(input logic [15:0] cw);
        logic [10:0] d;
        int unsigned idx;
        d   = '0;
        idx = 0;
        for (int unsigned k = 1; k < 16; k++) begin
            if ((k & (k - 1)) != 0) begin
                d[idx] = cw[k];
                idx++;
            end
        end
        return d;
    endfunction

    function automatic dec_exp_t m_decode(input logic [15:0] rx);
        dec_exp_t e;
        int unsigned s;
        bit odd;
        s = 0;
        for (int unsigned k = 0; k < 16; k++) if (rx[k]) s = s ^ k;
        odd   = ($countones(rx) % 2) != 0;
        e.v   = 1'b1;
        e.syn = s[3:0];
        e.sed = odd;
        e.ded = !odd && (s != 0);
        e.cw  = odd ? (rx ^ (16'h0001 << s)) : rx;
        e.data = m_extract(e.cw);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_enc_valid"}, 32'(enc_valid_out), 0);
        chk({tag, "_enc_cw"},    32'(enc_codeword_out), 0);
        chk({tag, "_dec_valid"}, 32'(dec_valid_out), 0);
        chk({tag, "_dec_cw"},    32'(dec_codeword_out), 0);
        chk({tag, "_dec_data"},  32'(dec_data_out), 0);
        chk({tag, "_dec_syn"},   32'(dec_syndrome), 0);
        chk({tag, "_dec_sed"},   32'(dec_sed), 0);
        chk({tag, "_dec_ded"},   32'(dec_ded), 0);
`ifdef HAMMING_ERR_CNT_EN
        chk({tag, "_sed_cnt"},   32'(sed_count), 0);
        chk({tag, "_ded_cnt"},   32'(ded_count), 0);
`endif
    endtask

    // One beat on both paths, driven on the falling edge; predictions queued at the same time.
    task automatic drive(input bit ev, input logic [10:0] ed, input bit dv, input logic [15:0] dcw);
        enc_exp_t ee;
        dec_exp_t de;
        @(negedge clk);
        rst             = 1'b0;
        enc_valid_in    = ev;
        enc_data_in     = ed;
        dec_valid_in    = dv;
        dec_codeword_in = dcw;
        ee.v  = ev;
        ee.cw = m_encode(ed);
        enc_q.push_back(ee);
        if (dv) begin
            de = m_decode(dcw);
        end else begin
            de = '{v: 1'b0, cw: '0, data: '0, syn: '0, sed: 1'b0, ded: 1'b0};
        end
        dec_q.push_back(de);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        enc_valid_in    = 1'b1;
        enc_data_in     = 11'($urandom);
        dec_valid_in    = 1'b1;
        dec_codeword_in = 16'($urandom);
        #1 rst = 1'b1;
        #1 check_all_zero("rst_async");
        enc_q.delete();
        dec_q.delete();
        hold_enc_cw  = '0;
        hold_dec_cw  = '0;
        hold_dec_dat = '0;
`ifdef HAMMING_ERR_CNT_EN
        exp_sed_cnt = '0;
        exp_ded_cnt = '0;
`endif
        @(posedge clk);
        #2 check_all_zero("rst_discard");
    endtask

    initial begin : monitor
        enc_exp_t ee;
        dec_exp_t de;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                chk("enc_q_nonempty", 32'(enc_q.size() != 0), 1);
                if (enc_q.size() != 0) begin
                    ee = enc_q.pop_front();
                    chk("enc_valid_out", 32'(enc_valid_out), 32'(ee.v));
                    if (ee.v) hold_enc_cw = ee.cw;
                    chk(ee.v ? "enc_codeword" : "enc_hold", 32'(enc_codeword_out), 32'(hold_enc_cw));
                end
                chk("dec_q_nonempty", 32'(dec_q.size() != 0), 1);
                if (dec_q.size() != 0) begin
                    de = dec_q.pop_front();
                    chk("dec_valid_out", 32'(dec_valid_out), 32'(de.v));
                    if (de.v) begin
                        hold_dec_cw  = de.cw;
                        hold_dec_dat = de.data;
                    end
                    chk(de.v ? "dec_codeword" : "dec_cw_hold", 32'(dec_codeword_out), 32'(hold_dec_cw));
                    chk(de.v ? "dec_data" : "dec_data_hold", 32'(dec_data_out), 32'(hold_dec_dat));
                    chk("dec_syndrome", 32'(dec_syndrome), 32'(de.syn));
                    chk("dec_sed", 32'(dec_sed), 32'(de.sed));
                    chk("dec_ded", 32'(dec_ded), 32'(de.ded));
`ifdef HAMMING_ERR_CNT_EN
                    chk("sed_count", 32'(sed_count), 32'(exp_sed_cnt));
                    chk("ded_count", 32'(ded_count), 32'(exp_ded_cnt));
                    if (de.v && de.sed && exp_sed_cnt != 16'hFFFF) exp_sed_cnt++;
                    if (de.v && de.ded && exp_ded_cnt != 16'hFFFF) exp_ded_cnt++;
`endif
                end
            end
        end
    end

    initial begin : stimulus
        logic [15:0] base;
        logic [15:0] cw;
        int unsigned b1;
        int unsigned b2;
        #1 check_all_zero("reset_state");

        drive(1, 11'h18E, 1, 16'h30F3);
        drive(1, 11'h000, 1, 16'h30F7);
        drive(1, 11'h7FF, 1, 16'h30F2);
        drive(0, 11'h155, 1, 16'h30FF);
        drive(0, 11'h2AA, 0, 16'hDEAD);
        drive(0, 11'h001, 0, 16'h0000);

        for (int unsigned b = 0; b < 16; b++) begin
            drive(1, 11'h000, 1, 16'h0000 ^ (16'h0001 << b));
            drive(1, 11'h7FF, 1, 16'hFFFF ^ (16'h0001 << b));
        end

        for (int unsigned n = 0; n < 400; n++) begin
            if (n == 150 || n == 300) mid_reset();
            base = m_encode(11'($urandom));
            b1   = $urandom_range(0, 15);
            b2   = (b1 + $urandom_range(1, 15)) % 16;
            case ($urandom_range(0, 2))
                0:       cw = base;
                1:       cw = base ^ (16'h0001 << b1);
                default: cw = base ^ (16'h0001 << b1) ^ (16'h0001 << b2);
            endcase
            drive($urandom_range(0, 3) != 0, 11'($urandom), $urandom_range(0, 3) != 0, cw);
        end

        drive(0, 11'h000, 0, 16'h0000);
        @(posedge clk);
        #3;
        chk("enc_q_drained", 32'(enc_q.size()), 0);
        chk("dec_q_drained", 32'(dec_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
